// File: rtl/scie_pkg.sv
// Shared SCIE definitions: custom opcodes, default datapath width, writeback entry type.
package scie_pkg;

  localparam logic [6:0] SCIE_OP_CUSTOM0 = 7'h0B;
  localparam logic [6:0] SCIE_OP_CUSTOM1 = 7'h2B;
  localparam logic [6:0] SCIE_OP_CUSTOM2 = 7'h5B;

  localparam int unsigned SCIE_XLEN = 32;

  typedef struct packed {
    logic [4:0]           rd;
    logic [SCIE_XLEN-1:0] data;
  } scie_wb_entry_t;

endpackage

// File: rtl/scie_wb_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when empty are ignored.
module scie_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push & (count != CW'(DEPTH));
  assign do_pop   = pop & (count != '0);
  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push & ~do_pop)      count <= count + CW'(1);
      else if (~do_push & do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/scie_writeback.sv
// SCIE writeback stage: tracks result-producing issues, captures rd after LATENCY cycles,
// buffers results and grants issue credits. Define SCIE_WB_BYPASS_EN for empty-FIFO bypass.
module scie_writeback
  import scie_pkg::*;
#(
  parameter int unsigned XLEN      = SCIE_XLEN,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned DEPTH     = 4,
  parameter logic [6:0]  WB_OPCODE = SCIE_OP_CUSTOM2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [31:0]     issue_insn,
  output logic            issue_ready,
  input  logic [XLEN-1:0] scie_rd,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [4:0]      resp_rd_addr,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = $clog2(LATENCY + 1);
  localparam int unsigned EW = XLEN + 5;

  logic [LATENCY-1:0] pipe_vld;
  logic [4:0]         pipe_rd [LATENCY];
  logic [IW-1:0]      inflight;
  logic [IW-1:0]      inflight_next;
  logic [CW-1:0]      fifo_count;
  logic [CW-1:0]      count_next;
  logic [EW-1:0]      fifo_head;
  logic               tracked;
  logic               capture;
  logic               bypass;
  logic               fifo_nonempty;
  logic               fifo_push;
  logic               fifo_pop;
  logic [19:0]        unused_insn_bits;

  assign unused_insn_bits = issue_insn[31:12];

  assign tracked = issue_valid & issue_ready & (issue_insn[6:0] == WB_OPCODE)
                 & (issue_insn[11:7] != 5'd0);
  assign capture       = pipe_vld[LATENCY-1];
  assign fifo_nonempty = (fifo_count != '0);

`ifdef SCIE_WB_BYPASS_EN
  assign bypass = capture & ~fifo_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed result taken in its capture cycle never occupies a FIFO slot.
  assign fifo_push = capture & ~(bypass & resp_ready);
  assign fifo_pop  = resp_ready & fifo_nonempty;

  always_comb begin
    resp_valid   = fifo_nonempty | bypass;
    resp_rd_addr = '0;
    resp_data    = '0;
    if (fifo_nonempty) begin
      resp_rd_addr = fifo_head[EW-1:XLEN];
      resp_data    = fifo_head[XLEN-1:0];
    end else if (bypass) begin
      resp_rd_addr = pipe_rd[LATENCY-1];
      resp_data    = scie_rd;
    end
  end

  always_comb begin
    inflight_next = inflight;
    if (tracked & ~capture)      inflight_next = inflight + IW'(1);
    else if (~tracked & capture) inflight_next = inflight - IW'(1);
    count_next = fifo_count;
    if (fifo_push & ~fifo_pop)      count_next = fifo_count + CW'(1);
    else if (~fifo_push & fifo_pop) count_next = fifo_count - CW'(1);
  end

  assign busy = (inflight != '0) | fifo_nonempty;

  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_vld    <= '0;
      inflight    <= '0;
      issue_ready <= 1'b0;
    end else begin
      pipe_vld[0] <= tracked;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
      inflight    <= inflight_next;
      issue_ready <= (32'(count_next) + 32'(inflight_next)) < DEPTH;
    end
  end

  always_ff @(posedge clock) begin
    pipe_rd[0] <= issue_insn[11:7];
    for (int unsigned i = 1; i < LATENCY; i++) pipe_rd[i] <= pipe_rd[i-1];
  end

  scie_wb_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({pipe_rd[LATENCY-1], scie_rd}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_scie_writeback.sv
// Randomized scoreboard bench for scie_writeback against a transaction-level model.
module tb_scie_writeback;
  import scie_pkg::*;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned LATENCY = 1;
  localparam int unsigned DEPTH   = 4;
`ifdef SCIE_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            issue_valid = 1'b0;
  logic [31:0]     issue_insn = '0;
  logic            issue_ready;
  logic [XLEN-1:0] scie_rd = '0;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [4:0]      resp_rd_addr;
  logic [XLEN-1:0] resp_data;
  logic            busy;

  scie_writeback #(
    .XLEN      (XLEN),
    .LATENCY   (LATENCY),
    .DEPTH     (DEPTH),
    .WB_OPCODE (SCIE_OP_CUSTOM2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_insn   (issue_insn),
    .issue_ready  (issue_ready),
    .scie_rd      (scie_rd),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rd_addr (resp_rd_addr),
    .resp_data    (resp_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  typedef struct { logic [4:0] rd; int unsigned due; } pend_t;
  typedef struct { scie_wb_entry_t e; int unsigned cap; } exp_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned issued = 0;
  int unsigned popped = 0;
  bit          hold_off = 1'b1;
  bit          exp_ready = 1'b0;
  bit          exp_busy = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // One clock cycle of stimulus; the model advances from its own rules, not from DUT outputs.
  task automatic step(input logic rst, input logic iv, input logic [31:0] insn,
                      input logic [XLEN-1:0] rdv, input logic rr);
    scie_wb_entry_t e;
    exp_t x;
    pend_t p;
    @(posedge clock);
    #1;
    cyc++;
    reset = rst; issue_valid = iv; issue_insn = insn; scie_rd = rdv; resp_ready = rr;
    if (rst) begin
      pend.delete(); exp_q.delete();
      issued = 0; popped = 0;
      exp_ready = 1'b0; exp_busy = 1'b0; hold_off = 1'b1;
    end else begin
      exp_busy  = (issued - popped) != 0;
      exp_ready = !hold_off && ((issued - popped) < DEPTH);
      hold_off  = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e.rd = pend[0].rd; e.data = rdv;
        x.e = e; x.cap = cyc;
        exp_q.push_back(x);
        void'(pend.pop_front());
      end
      if (iv && exp_ready && insn[6:0] == SCIE_OP_CUSTOM2 && insn[11:7] != 5'd0) begin
        p.rd = insn[11:7]; p.due = cyc + LATENCY;
        pend.push_back(p);
        issued++;
      end
    end
  endtask

  function automatic logic [31:0] wb_insn(input logic [4:0] rd);
    logic [31:0] w;
    w = $urandom;
    w[11:7] = rd;
    w[6:0]  = SCIE_OP_CUSTOM2;
    return w;
  endfunction

  always @(negedge clock) begin
    bit ev;
    if (!reset && cyc > 0) begin
      ev = (exp_q.size() > 0) && (BYPASS || exp_q[0].cap < cyc);
      check("issue_ready", 64'(issue_ready), 64'(exp_ready));
      check("busy", 64'(busy), 64'(exp_busy));
      check("resp_valid", 64'(resp_valid), 64'(ev));
      if (ev) begin
        check("resp_rd_addr", 64'(resp_rd_addr), 64'(exp_q[0].e.rd));
        check("resp_data", 64'(resp_data), 64'(exp_q[0].e.data));
        if (resp_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  end

  initial begin
    logic [31:0] vals [4];
    logic [31:0] w;
    vals[0] = 32'd5; vals[1] = 32'd8; vals[2] = 32'd12; vals[3] = 32'd14;

    step(1, 0, '0, '0, 0);
    step(1, 0, '0, '0, 0);
    step(0, 0, '0, '0, 1);
    step(0, 0, '0, '0, 1);

    // Basic result: rd=2, data 3 one cycle after issue.
    step(0, 1, 32'h0000015B, 32'hDEAD, 1);
    step(0, 0, '0, 32'd3, 1);
    step(0, 0, '0, 32'h77, 1);
    step(0, 0, '0, 32'h78, 1);

    // Non-writeback opcodes and rd=0.
    step(0, 1, 32'h0000008B, 32'h1, 1);
    step(0, 1, 32'h0000012B, 32'h2, 1);
    step(0, 1, 32'h0000005B, 32'h3, 1);
    step(0, 0, '0, 32'h4, 1);
    step(0, 0, '0, 32'h5, 1);

    // Back-pressure: fill all credits, then drain in order.
    for (int i = 0; i < 5; i++)
      step(0, i < 4, wb_insn(5'(i + 1)), (i > 0) ? vals[i-1] : $urandom, 0);
    for (int i = 0; i < 3; i++) step(0, 1, wb_insn(5'd9), $urandom, 0);
    for (int i = 0; i < 6; i++) step(0, 0, '0, $urandom, 1);

    // Hold two entries, then capture and pop every cycle across the wrap point.
    step(0, 1, wb_insn(5'd10), $urandom, 0);
    step(0, 1, wb_insn(5'd11), $urandom, 0);
    step(0, 0, '0, $urandom, 0);
    for (int i = 0; i < 8; i++) step(0, 1, wb_insn(5'(12 + i)), $urandom, 1);
    for (int i = 0; i < 4; i++) step(0, 0, '0, $urandom, 1);

    // Reset with three buffered and one in flight.
    for (int i = 0; i < 4; i++) step(0, 1, wb_insn(5'(20 + i)), $urandom, 0);
    step(1, 0, '0, 32'hBADBAD, 1);
    step(0, 0, '0, 32'hBADBAD, 1);
    step(0, 0, '0, $urandom, 1);

    for (int i = 0; i < 3000; i++) begin
      w = $urandom;
      case ($urandom_range(0, 5))
        0:       w[6:0] = SCIE_OP_CUSTOM0;
        1:       w[6:0] = SCIE_OP_CUSTOM1;
        2:       begin w[6:0] = SCIE_OP_CUSTOM2; w[11:7] = 5'd0; end
        default: w[6:0] = SCIE_OP_CUSTOM2;
      endcase
      step(i == 1500, ($urandom_range(0, 9) < 6), w, $urandom, ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 20; i++) step(0, 0, '0, $urandom, 1);
    @(posedge clock);
    #1;
    check("drain_results", 64'(exp_q.size()), 64'd0);
    check("drain_inflight", 64'(pend.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
